// File: rtl/text_memory_arbiter_if.sv
// Bus bundle between the text memory arbiter, its two requesters and the text memory.
// slave: the arbiter's view; master: the environment (fetch, debug, memory).
interface text_memory_arbiter_if #(
    parameter int unsigned TEXT_BITS = 12
);
    // Fetch port
    logic                 f_req;
    logic [31:0]          f_address;
    logic                 f_gnt;
    logic                 f_rvalid;
    logic [31:0]          f_rdata;
    // Debug / loader port
    logic                 d_req;
    logic                 d_we;
    logic [31:0]          d_address;
    logic [31:0]          d_wdata;
    logic [3:0]           d_be;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [31:0]          d_rdata;
    logic                 d_err;
    // Text memory side
    logic [TEXT_BITS-3:0] mem_address;
    logic                 mem_wren;
    logic [3:0]           mem_byteena;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_q;

    modport slave (
        input  f_req, f_address,
        input  d_req, d_we, d_address, d_wdata, d_be,
        input  mem_q,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_wren, mem_byteena, mem_wdata
    );

    modport master (
        output f_req, f_address,
        output d_req, d_we, d_address, d_wdata, d_be,
        output mem_q,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_wren, mem_byteena, mem_wdata
    );
endinterface

// File: rtl/text_memory_arbiter.sv
// Shares the single-port text memory between instruction fetch (priority) and the
// debug/loader port, with an anti-starvation counter that forces a debug grant.
// Responses come back one cycle after the grant, routed by a registered owner tag.
// Optional macro TEXT_ARB_RANGE_CHECK_EN: out-of-range accesses are granted but
// return 0, suppress the memory write and flag d_err on the debug port.
module text_memory_arbiter #(
    parameter int unsigned TEXT_BITS    = 12,
    parameter logic [31:0] TEXT_BEGIN   = 32'h0000_0000,
    parameter logic [31:0] TEXT_END     = 32'h0000_0FFF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    text_memory_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic we;
        logic err;
    } owner_t;

    logic [CNT_W-1:0] starve_cnt;
    owner_t           owner_q;
    logic             f_gnt_c;
    logic             d_gnt_c;
    logic             in_range_c;
    logic             err_c;
    logic [31:0]      resp_data_c;

    // Fixed priority to fetch unless debug has waited STARVE_LIMIT cycles
    always_comb begin
        f_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        if ((starve_cnt == LIMIT) && bus.d_req) begin
            d_gnt_c = 1'b1;
        end else if (bus.f_req) begin
            f_gnt_c = 1'b1;
        end else if (bus.d_req) begin
            d_gnt_c = 1'b1;
        end
    end

`ifdef TEXT_ARB_RANGE_CHECK_EN
    logic [31:0] sel_address;
    logic        below_begin;
    logic        above_end;
    logic [31:0] below_rem_unused;
    logic [31:0] above_rem_unused;

    assign sel_address = d_gnt_c ? bus.d_address : bus.f_address;
    // Borrow out of a 33-bit subtract gives the unsigned compare without constant-compare hazards
    assign {below_begin, below_rem_unused} = {1'b0, sel_address} - {1'b0, TEXT_BEGIN};
    assign {above_end, above_rem_unused}   = {1'b0, TEXT_END} - {1'b0, sel_address};
    assign in_range_c = ~below_begin & ~above_end;
`else
    // Without the range check the upper address bits are simply dropped (wraps)
    assign in_range_c = 1'b1;
`endif

    assign err_c = (f_gnt_c | d_gnt_c) & ~in_range_c;

    // Memory drive: granted address, fetch address when idle
    always_comb begin
        bus.mem_address = bus.f_address[TEXT_BITS-1:2];
        bus.mem_byteena = 4'hF;
        if (d_gnt_c) begin
            bus.mem_address = bus.d_address[TEXT_BITS-1:2];
            bus.mem_byteena = bus.d_be;
        end
        bus.mem_wren  = d_gnt_c & bus.d_we & in_range_c;
        bus.mem_wdata = bus.d_wdata;
        bus.f_gnt     = f_gnt_c;
        bus.d_gnt     = d_gnt_c;
    end

    // Anti-starvation counter: counts denied debug cycles, saturates at the limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!bus.d_req || d_gnt_c) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Owner tag for the response that the memory returns next cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= '{valid: 1'b0, owner: OWN_F, we: 1'b0, err: 1'b0};
        end else begin
            owner_q <= '{valid: f_gnt_c | d_gnt_c,
                         owner: d_gnt_c ? OWN_D : OWN_F,
                         we:    d_gnt_c & bus.d_we,
                         err:   err_c};
        end
    end

    // Response routing: one rvalid per grant, unselected data forced to 0
    always_comb begin
        resp_data_c  = owner_q.err ? 32'h0 : bus.mem_q;
        bus.f_rvalid = owner_q.valid & (owner_q.owner == OWN_F);
        bus.d_rvalid = owner_q.valid & (owner_q.owner == OWN_D);
        bus.f_rdata  = 32'h0;
        bus.d_rdata  = 32'h0;
        bus.d_err    = bus.d_rvalid & owner_q.err;
        if (bus.f_rvalid) begin
            bus.f_rdata = resp_data_c;
        end
        if (bus.d_rvalid && !owner_q.we) begin
            bus.d_rdata = resp_data_c;
        end
    end

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Directed bench for text_memory_arbiter with a behavioural 1-cycle text memory
// and a per-port scoreboard of expected responses.
module tb_text_memory_arbiter;

    localparam int unsigned TEXT_BITS = 12;
    localparam int unsigned WORDS     = 1 << (TEXT_BITS - 2);

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock;
    logic        reset_n;
    int          total;
    int          bad;
    int          cyc;
    exp_t        fq[$];
    exp_t        dq[$];
    exp_t        fe;
    exp_t        de;
    logic [31:0] mem [WORDS];

    text_memory_arbiter_if #(.TEXT_BITS(TEXT_BITS)) bus ();

    text_memory_arbiter #(
        .TEXT_BITS   (TEXT_BITS),
        .TEXT_BEGIN  (32'h0000_0000),
        .TEXT_END    (32'h0000_0FFF),
        .STARVE_LIMIT(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port memory: byte-enabled write, registered read
    initial begin
        for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h100 + 32'(i);
        mem[4] = 32'h1234_5678;
        bus.mem_q = 32'h0;
        forever begin
            @(posedge clock);
            if (bus.mem_wren) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteena[b]) mem[bus.mem_address][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
            bus.mem_q <= mem[bus.mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: each rvalid must match the oldest expected item, one cycle after grant
    always @(negedge clock) begin
        if (bus.f_rvalid) begin
            chk("f_rvalid_expected", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) begin
                fe = fq.pop_front();
                chk("f_latency", 32'(cyc), 32'(fe.cyc + 1));
                chk("f_rdata", bus.f_rdata, fe.data);
            end
        end
        if (bus.d_rvalid) begin
            chk("d_rvalid_expected", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
                de = dq.pop_front();
                chk("d_latency", 32'(cyc), 32'(de.cyc + 1));
                chk("d_rdata", bus.d_rdata, de.data);
                chk("d_err", 32'(bus.d_err), 32'(de.err));
            end
        end
    end

    task automatic step(input logic fr, input logic [31:0] fa,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe,
                        input logic efg, input logic edg, input logic ewren,
                        input logic [31:0] edata, input logic eerr, input string tag);
        bus.f_req     = fr;
        bus.f_address = fa;
        bus.d_req     = dr;
        bus.d_we      = dw;
        bus.d_address = da;
        bus.d_wdata   = dwd;
        bus.d_be      = dbe;
        @(negedge clock);
        chk({tag, "_fgnt"}, 32'(bus.f_gnt), 32'(efg));
        chk({tag, "_dgnt"}, 32'(bus.d_gnt), 32'(edg));
        chk({tag, "_wren"}, 32'(bus.mem_wren), 32'(ewren));
        if (efg) fq.push_back('{cyc: cyc, data: edata, err: eerr});
        if (edg) dq.push_back('{cyc: cyc, data: edata, err: eerr});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_f_rvalid"}, 32'(bus.f_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
        chk({tag, "_d_err"}, 32'(bus.d_err), 32'd0);
        chk({tag, "_f_rdata"}, bus.f_rdata, 32'h0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset_n = 1'b0;
        bus.f_req = 1'b0; bus.f_address = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_address = 32'h0;
        bus.d_wdata = 32'h0; bus.d_be = 4'h0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_quiet("reset");
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Fetch only, back-to-back
        step(1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h100, 0, "fetch0");
        step(1, 32'h4, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h101, 0, "fetch1");
        step(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h102, 0, "fetch2");
        step(1, 32'h6, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h101, 0, "fetch_misaligned");
        idle("idle0");

        // Debug partial write then read back
        step(0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'b0011, 0, 1, 1, 32'h0, 0, "dbg_wr");
        step(0, 32'h0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 0, 32'h1234_BEEF, 0, "dbg_rd");

        // Write followed immediately by a fetch of the same word
        step(0, 32'h0, 1, 1, 32'h20, 32'hA5A5_A5A5, 4'hF, 0, 1, 1, 32'h0, 0, "haz_wr");
        step(1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'hA5A5_A5A5, 0, "haz_rd");
        idle("idle1");

        // Starvation: debug wins on the fifth contended cycle, then fetch regains
        for (int i = 0; i < 4; i++)
            step(1, 32'h0, 1, 0, 32'h10, 32'h0, 4'h0, 1, 0, 0, 32'h100, 0, "starve_wait");
        step(1, 32'h0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 0, 32'h1234_BEEF, 0, "starve_win");
        step(1, 32'h4, 1, 0, 32'h10, 32'h0, 4'h0, 1, 0, 0, 32'h101, 0, "starve_regain");
        step(0, 32'h0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 0, 32'h1234_BEEF, 0, "starve_drain");

        // Simultaneous requests below the limit: fetch first, debug write next
        step(1, 32'h8, 1, 1, 32'h30, 32'h55, 4'hF, 1, 0, 0, 32'h102, 0, "simul_f");
        step(0, 32'h0, 1, 1, 32'h30, 32'h55, 4'hF, 0, 1, 1, 32'h0, 0, "simul_d");
        step(1, 32'h30, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h55, 0, "simul_chk");
        idle("idle2");

        // Access beyond TEXT_END
`ifdef TEXT_ARB_RANGE_CHECK_EN
        step(0, 32'h0, 1, 1, 32'h1003, 32'hCAFE_F00D, 4'hF, 0, 1, 0, 32'h0, 1, "range_wr");
        step(0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'h100, 0, "range_rd0");
        step(1, 32'h2000, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h0, 1, "range_fetch");
`else
        step(0, 32'h0, 1, 1, 32'h1003, 32'hCAFE_F00D, 4'hF, 0, 1, 1, 32'h0, 0, "range_wr");
        step(0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'hCAFE_F00D, 0, "range_rd0");
        step(1, 32'h2000, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'hCAFE_F00D, 0, "range_fetch");
`endif
        idle("idle3");

        // Reset the cycle after a debug read grant: the response is dropped
        step(0, 32'h0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 0, 32'h1234_BEEF, 0, "rst_rd");
        reset_n = 1'b0;
        bus.d_req = 1'b0;
        dq.delete();
        @(negedge clock);
        chk_quiet("midreset");
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk_quiet("post_reset");
        chk("post_reset_fgnt", 32'(bus.f_gnt), 32'd0);
        chk("post_reset_dgnt", 32'(bus.d_gnt), 32'd0);
        @(posedge clock);
        #1;
        step(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 32'h102, 0, "post_reset_fetch");
        idle("idle4");
        idle("idle5");

        // Every expected response must have been delivered
        chk("fq_drained", 32'(fq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
